// File: rtl/four_bit_1x2_demux_buffered_if.sv
// Handshake bundle between the shared 4-bit link, the demux and its two channel consumers.
// The demux side uses the slave modport; the driving/consuming environment uses master.
interface four_bit_1x2_demux_buffered_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    In;
  logic          Select;
  logic          In_valid;
  logic          In_ready;
  logic [3:0]    Out_0;
  logic          Out_0_valid;
  logic          Out_0_ready;
  logic [3:0]    Out_1;
  logic          Out_1_valid;
  logic          Out_1_ready;
  logic [CW-1:0] Count_0;
  logic [CW-1:0] Count_1;

  modport slave (
    input  In, Select, In_valid, Out_0_ready, Out_1_ready,
    output In_ready, Out_0, Out_0_valid, Out_1, Out_1_valid, Count_0, Count_1
  );

  modport master (
    output In, Select, In_valid, Out_0_ready, Out_1_ready,
    input  In_ready, Out_0, Out_0_valid, Out_1, Out_1_valid, Count_0, Count_1
  );
endinterface

// File: rtl/four_bit_1x2_demux_buffered.sv
// 1-to-2 demultiplexer for a time-multiplexed 4-bit stream; each channel is buffered
// in its own DEPTH-entry FIFO and drained independently via valid/ready.
module four_bit_1x2_demux_buffered #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  four_bit_1x2_demux_buffered_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    word_out  [2];
  logic [CW-1:0] count_out [2];
  logic [1:0]    valid_out;
  logic [1:0]    full;
  logic [1:0]    pop_ready;

  assign pop_ready = {bus.Out_1_ready, bus.Out_0_ready};

  // Readiness follows only the addressed channel and ignores any same-cycle pop.
  assign bus.In_ready = ~full[bus.Select];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [3:0]    mem_q [DEPTH];
      logic [AW-1:0] wr_q, wr_d;
      logic [AW-1:0] rd_q, rd_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          push;
      logic          pop;

      assign push = bus.In_valid && !full[bus.Select] && (int'(bus.Select) == gi);
      assign pop  = (cnt_q != '0) && pop_ready[gi];

      always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + AW'(1);
        if (pop)  rd_d = rd_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
        end else begin
          wr_q  <= wr_d;
          rd_q  <= rd_d;
          cnt_q <= cnt_d;
        end
      end

      // Storage carries no reset; stale contents are masked by the occupancy count.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.In;
      end

      assign full[gi]      = (cnt_q == CW'(DEPTH));
      assign valid_out[gi] = (cnt_q != '0);
      assign word_out[gi]  = valid_out[gi] ? mem_q[rd_q] : 4'b0000;
      assign count_out[gi] = cnt_q;
    end
  endgenerate

  assign bus.Out_0       = word_out[0];
  assign bus.Out_0_valid = valid_out[0];
  assign bus.Count_0     = count_out[0];
  assign bus.Out_1       = word_out[1];
  assign bus.Out_1_valid = valid_out[1];
  assign bus.Count_1     = count_out[1];
endmodule

// File: tb/tb_four_bit_1x2_demux_buffered.sv
// Directed bench for the buffered 1x2 demux: a per-cycle vector table plus
// hand-written full, simultaneous, wrap-around, reset and routing sequences.
module tb_four_bit_1x2_demux_buffered;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  four_bit_1x2_demux_buffered_if #(.DEPTH(4)) bus ();

  four_bit_1x2_demux_buffered #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       sel;
    logic [3:0] din;
    logic       vld;
    logic       r0;
    logic       r1;
    logic [3:0] e_o0;
    logic       e_v0;
    logic [3:0] e_o1;
    logic       e_v1;
    logic [2:0] e_c0;
    logic [2:0] e_c1;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [3:0] din, input logic vld,
                       input logic r0, input logic r1);
    bus.Select      = sel;
    bus.In          = din;
    bus.In_valid    = vld;
    bus.Out_0_ready = r0;
    bus.Out_1_ready = r1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out0"},   {4'h0, bus.Out_0}, 8'h00);
    chk({tag, "_v0"},     {7'h0, bus.Out_0_valid}, 8'h00);
    chk({tag, "_out1"},   {4'h0, bus.Out_1}, 8'h00);
    chk({tag, "_v1"},     {7'h0, bus.Out_1_valid}, 8'h00);
    chk({tag, "_cnt0"},   {5'h0, bus.Count_0}, 8'h00);
    chk({tag, "_cnt1"},   {5'h0, bus.Count_1}, 8'h00);
    chk({tag, "_inrdy"},  {7'h0, bus.In_ready}, 8'h01);
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 4'h0, 1'b0, 3'd1, 3'd0};
    tbl[1] = '{1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 4'h0, 1'b0, 3'd2, 3'd0};
    tbl[2] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 4'h5, 1'b1, 3'd2, 3'd1};
    tbl[3] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 4'h5, 1'b1, 3'd1, 3'd1};
    tbl[4] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h5, 1'b1, 3'd0, 3'd1};
    tbl[5] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0};
    tbl[6] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0};
    tbl[7] = '{1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 4'h0, 1'b0, 3'd1, 3'd0};
    tbl[8] = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h9, 1'b1, 3'd0, 3'd1};
    tbl[9] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 3'd0};

    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk_idle("por");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Vector table: inputs held for one edge, outputs compared just after it.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].sel, tbl[i].din, tbl[i].vld, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("vec%0d_inrdy", i), {7'h0, bus.In_ready}, 8'h01);
      step();
      chk($sformatf("vec%0d_out0", i), {4'h0, bus.Out_0}, {4'h0, tbl[i].e_o0});
      chk($sformatf("vec%0d_v0", i),   {7'h0, bus.Out_0_valid}, {7'h0, tbl[i].e_v0});
      chk($sformatf("vec%0d_out1", i), {4'h0, bus.Out_1}, {4'h0, tbl[i].e_o1});
      chk($sformatf("vec%0d_v1", i),   {7'h0, bus.Out_1_valid}, {7'h0, tbl[i].e_v1});
      chk($sformatf("vec%0d_cnt0", i), {5'h0, bus.Count_0}, {5'h0, tbl[i].e_c0});
      chk($sformatf("vec%0d_cnt1", i), {5'h0, bus.Count_1}, {5'h0, tbl[i].e_c1});
    end

    // Full channel 1, then a held 5th word enters only after one pop.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    chk("full_cnt1", {5'h0, bus.Count_1}, 8'h04);
    drive(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
    #1;
    chk("full_inrdy_sel1", {7'h0, bus.In_ready}, 8'h00);
    bus.Select = 1'b0;
    #1;
    chk("full_inrdy_sel0", {7'h0, bus.In_ready}, 8'h01);
    bus.Select = 1'b1;
    step();
    step();
    chk("full_hold_cnt1", {5'h0, bus.Count_1}, 8'h04);
    chk("full_hold_out1", {4'h0, bus.Out_1}, 8'h01);
    chk("full_hold_cnt0", {5'h0, bus.Count_0}, 8'h00);
    bus.Out_1_ready = 1'b1;
    step();
    chk("full_pop_cnt1", {5'h0, bus.Count_1}, 8'h03);
    chk("full_pop_out1", {4'h0, bus.Out_1}, 8'h02);
    chk("full_pop_inrdy", {7'h0, bus.In_ready}, 8'h01);
    bus.Out_1_ready = 1'b0;
    step();
    chk("full_push5_cnt1", {5'h0, bus.Count_1}, 8'h04);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] exp_seq [4];
      exp_seq = '{4'h3, 4'h4, 4'hE, 4'h0};
      step();
      chk($sformatf("full_drain%0d_out1", i), {4'h0, bus.Out_1}, {4'h0, exp_seq[i]});
    end
    chk("full_drain_v1", {7'h0, bus.Out_1_valid}, 8'h00);

    // Simultaneous push and pop on channel 0 holding two words.
    drive(1'b0, 4'hB, 1'b1, 1'b0, 1'b0);
    step();
    bus.In = 4'hC;
    step();
    chk("sim_pre_cnt0", {5'h0, bus.Count_0}, 8'h02);
    drive(1'b0, 4'hD, 1'b1, 1'b1, 1'b0);
    step();
    chk("sim_cnt0", {5'h0, bus.Count_0}, 8'h02);
    chk("sim_out0", {4'h0, bus.Out_0}, 8'h0C);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    chk("sim_next_out0", {4'h0, bus.Out_0}, 8'h0D);
    step();
    chk("sim_empty_v0", {7'h0, bus.Out_0_valid}, 8'h00);

    // Wrap-around: 16 words stream through channel 0 with its consumer always ready.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 1'b1, 1'b1, 1'b0);
      step();
      chk($sformatf("wrap%0d_out0", i), {4'h0, bus.Out_0}, 8'(i));
      chk($sformatf("wrap%0d_cnt_le1", i), {7'h0, (bus.Count_0 <= 3'd1)}, 8'h01);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    chk("wrap_end_cnt0", {5'h0, bus.Count_0}, 8'h00);

    // Exhaustive routing with both consumers always ready.
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 16; v++) begin
        drive(1'(s), 4'(v), 1'b1, 1'b1, 1'b1);
        step();
        if (s == 0) begin
          chk($sformatf("route_s0_v%0d_out0", v), {3'h0, bus.Out_0_valid, bus.Out_0}, 8'h10 | 8'(v));
          chk($sformatf("route_s0_v%0d_v1", v), {7'h0, bus.Out_1_valid}, 8'h00);
        end else begin
          chk($sformatf("route_s1_v%0d_out1", v), {3'h0, bus.Out_1_valid, bus.Out_1}, 8'h10 | 8'(v));
          chk($sformatf("route_s1_v%0d_v0", v), {7'h0, bus.Out_0_valid}, 8'h00);
        end
      end
    end

    // Mid-operation asynchronous reset discards buffered words without a clock edge.
    drive(1'b0, 4'h6, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chk("pre_rst_cnt0", {5'h0, bus.Count_0}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    step();
    chk("postrst_out1", {4'h0, bus.Out_1}, 8'h0F);
    chk("postrst_cnt1", {5'h0, bus.Count_1}, 8'h01);
    chk("postrst_cnt0", {5'h0, bus.Count_0}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
